lcd_timing_gen: RTL and testbench



---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_align_pipe.sv | 34 +++
 rtl/lcd_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared timing defaults, payload types and FSM states for the LCD raster generator.
package lcd_pkg;

  localparam int unsigned RGB_W = 24;

  // Default 800x480 panel timing.
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 21;
  localparam int unsigned DEF_READ_LAT = 2;
  localparam int unsigned DEF_CW       = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lcd_state_e;

  // Control bits carried through the read-latency delay line.
  typedef struct packed {
    logic req;
    logic hs;
    logic vs;
  } align_t;

endpackage

// File: rtl/lcd_align_pipe.sv
// Fixed-depth delay line that keeps request and sync flags aligned with returning pixels.
module lcd_align_pipe
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   flush,
  input  align_t din,
  output align_t dout
);

  if (DEPTH == 0) begin : g_pass
    // Zero latency: the reader answers in the request cycle.
    logic unused_c;
    assign unused_c = clk ^ flush;
    assign dout     = din;
  end else begin : g_sr
    align_t sr [DEPTH];

    // Shift register with synchronous flush.
    always_ff @(posedge clk) begin
      if (flush) begin
        for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: counts the pixel grid, requests pixels from the frame-buffer
// reader and emits hsync/vsync/de with the returned pixel aligned to de.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned READ_LAT = DEF_READ_LAT,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             enable,
  output logic             data_req,
  output logic [CW-1:0]    x,
  output logic [CW-1:0]    y,
  output logic             frame_start,
  input  logic [RGB_W-1:0] pix_in,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so region bounds equal to 2^CW still compare correctly.
  localparam int unsigned EW = CW + 1;

  localparam logic [EW-1:0] H_ACT_E  = EW'(H_ACTIVE);
  localparam logic [EW-1:0] H_SS_E   = EW'(H_ACTIVE + H_FP);
  localparam logic [EW-1:0] H_SE_E   = EW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EW-1:0] H_LAST_E = EW'(H_TOTAL - 1);
  localparam logic [EW-1:0] V_ACT_E  = EW'(V_ACTIVE);
  localparam logic [EW-1:0] V_SS_E   = EW'(V_ACTIVE + V_FP);
  localparam logic [EW-1:0] V_SE_E   = EW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [EW-1:0] V_LAST_E = EW'(V_TOTAL - 1);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt, v_nxt;
  logic [EW-1:0] h_e, v_e;
  logic          h_wrap_c, v_wrap_c;
  logic          run_c, flush_c;
  logic          req_c, hs_c, vs_c;
  logic          hs_q, vs_q;
  align_t        pipe_in, pipe_out;

  assign h_e      = {1'b0, h_cnt};
  assign v_e      = {1'b0, v_cnt};
  assign h_wrap_c = (h_e == H_LAST_E);
  assign v_wrap_c = (v_e == V_LAST_E);

  // Lock loss behaves like reset for everything downstream of the counters.
  assign flush_c  = reset | ~pll_locked;
  assign run_c    = (state_q == RUN) & pll_locked;

  // Next state and next counter values; counters sit at 0 outside RUN.
  always_comb begin
    state_d = state_q;
    h_nxt   = '0;
    v_nxt   = '0;
    case (state_q)
      IDLE: begin
        if (pll_locked && enable) state_d = RUN;
      end
      RUN: begin
        if (!pll_locked) begin
          state_d = IDLE;
        end else begin
          if (h_wrap_c && v_wrap_c && !enable) state_d = IDLE;
          if (h_wrap_c) begin
            h_nxt = '0;
            v_nxt = v_wrap_c ? '0 : v_cnt + CW'(1);
          end else begin
            h_nxt = h_cnt + CW'(1);
            v_nxt = v_cnt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      state_q <= state_d;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
    end
  end

  // Region decode from the current counter position.
  always_comb begin
    req_c = run_c & (h_e < H_ACT_E) & (v_e < V_ACT_E);
    hs_c  = run_c & (h_e >= H_SS_E) & (h_e < H_SE_E);
    vs_c  = run_c & (v_e >= V_SS_E) & (v_e < V_SE_E);
  end

  // Request stage: registered request, coordinates and raw syncs.
  always_ff @(posedge clk) begin
    if (flush_c) begin
      data_req    <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      data_req    <= req_c;
      x           <= h_cnt;
      y           <= v_cnt;
      frame_start <= req_c & (h_cnt == '0) & (v_cnt == '0);
      hs_q        <= hs_c;
      vs_q        <= vs_c;
    end
  end

  assign pipe_in = '{req: data_req, hs: hs_q, vs: vs_q};

  lcd_align_pipe #(
    .DEPTH (READ_LAT)
  ) u_align (
    .clk   (clk),
    .flush (flush_c),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  // Output stage: capture the returning pixel and drive polarity-adjusted syncs.
  always_ff @(posedge clk) begin
    if (flush_c) begin
      de      <= 1'b0;
      rgb_out <= '0;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
    end else begin
      de      <= pipe_out.req;
      rgb_out <= pipe_out.req ? pix_in : '0;
      hsync   <= pipe_out.hs ? HS_POL : ~HS_POL;
      vsync   <= pipe_out.vs ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen on a 14x7 raster: instance a uses READ_LAT=2,
// instance b uses READ_LAT=0. Expected events are queued per output kind and popped
// by a monitor whenever the DUT asserts that output.
module tb_lcd_timing_gen;

  localparam int BIG = 1 << 30;
  localparam logic [63:0] RST_EXP = 64'h3;

  typedef struct {
    int          cyc;
    logic [23:0] val;
  } ev_t;

  // Kinds: 0 fs_a, 1 fs_b, 2 de_a, 3 de_b, 4 hs_a, 5 hs_b, 6 vs_a, 7 vs_b
  ev_t q [8][$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lock = 1'b0;
  logic        enable = 1'b0;

  logic        req_a, fs_a, hs_a, vs_a, de_a;
  logic [10:0] x_a, y_a;
  logic [23:0] pix_a, rgb_a;
  logic        req_b, fs_b, hs_b, vs_b, de_b;
  logic [10:0] x_b, y_b;
  logic [23:0] pix_b, rgb_b;

  int   cyc = 0;
  logic rst_q = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [22:0] h1 = '0;
  logic [22:0] h2 = '0;

  always #5 clk = ~clk;

  function automatic logic [23:0] pat(input int px, input int py);
    return {8'h5A, 8'(py), 8'(px)};
  endfunction

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .READ_LAT(2), .CW(11)
  ) u_a (
    .clk(clk), .reset(reset), .pll_locked(lock), .enable(enable),
    .data_req(req_a), .x(x_a), .y(y_a), .frame_start(fs_a),
    .pix_in(pix_a), .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb_out(rgb_a)
  );

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .READ_LAT(0), .CW(11)
  ) u_b (
    .clk(clk), .reset(reset), .pll_locked(lock), .enable(enable),
    .data_req(req_b), .x(x_b), .y(y_b), .frame_start(fs_b),
    .pix_in(pix_b), .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb_out(rgb_b)
  );

  // Frame-buffer reader models: answer each request with its coordinate pattern,
  // and drive junk when no answer is due.
  always @(posedge clk) begin
    h1 <= {req_a, x_a, y_a};
    h2 <= h1;
  end
  assign pix_a = h2[22] ? pat(int'(h2[21:11]), int'(h2[10:0])) : (24'hC0FFEE ^ 24'(cyc));
  assign pix_b = req_b ? pat(int'(x_b), int'(y_b)) : (24'hBADBAD ^ 24'(cyc));

  // Cycle index: 1 on the first edge after reset release.
  always @(posedge clk) begin
    rst_q <= reset;
    cyc   <= reset ? 0 : cyc + 1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic ev_chk(input int k, input string nm, input bit present, input logic [23:0] val);
    ev_t e;
    if (present) begin
      if (q[k].size() == 0) begin
        check({nm, "_extra"}, {8'h0, 32'(cyc), val}, '1);
      end else begin
        e = q[k].pop_front();
        check(nm, {8'h0, 32'(cyc), val}, {8'h0, 32'(e.cyc), e.val});
      end
    end
  endtask

  // Monitor: reset values while in reset, otherwise pop one event per asserted output.
  always @(negedge clk) begin
    if (rst_q) begin
      check("reset_a", {13'd0, req_a, fs_a, x_a, y_a, de_a, rgb_a, hs_a, vs_a}, RST_EXP);
      check("reset_b", {13'd0, req_b, fs_b, x_b, y_b, de_b, rgb_b, hs_b, vs_b}, RST_EXP);
    end else begin
      ev_chk(0, "fs_a", fs_a, {req_a, 1'b0, x_a, y_a});
      ev_chk(1, "fs_b", fs_b, {req_b, 1'b0, x_b, y_b});
      ev_chk(2, "de_a", de_a, rgb_a);
      ev_chk(3, "de_b", de_b, rgb_b);
      ev_chk(4, "hs_a", !hs_a, 24'h0);
      ev_chk(5, "hs_b", !hs_b, 24'h0);
      ev_chk(6, "vs_a", !vs_a, 24'h0);
      ev_chk(7, "vs_b", !vs_b, 24'h0);
      if (!de_a) check("rgb_idle_a", 64'(rgb_a), 64'h0);
      if (!de_b) check("rgb_idle_b", 64'(rgb_b), 64'h0);
    end
  end

  task automatic push(input int k, input int c, input logic [23:0] v, input int cut);
    ev_t e;
    if (c <= cut) begin
      e.cyc = c;
      e.val = v;
      q[k].push_back(e);
    end
  endtask

  // Expected events of one frame whose first RUN cycle is s+1; events after cut are dropped.
  task automatic push_frame(input int s, input int cut);
    int r;
    push(0, s + 2, 24'h800000, cut);
    push(1, s + 2, 24'h800000, cut);
    for (int py = 0; py < 4; py++)
      for (int px = 0; px < 8; px++) begin
        r = s + 2 + 14 * py + px;
        push(2, r + 3, pat(px, py), cut);
        push(3, r + 1, pat(px, py), cut);
      end
    for (int l = 0; l < 7; l++)
      for (int d = 0; d < 2; d++) begin
        r = s + 12 + 14 * l + d;
        push(4, r + 3, 24'h0, cut);
        push(5, r + 1, 24'h0, cut);
      end
    for (int i = 0; i < 14; i++) begin
      push(6, s + 75 + i, 24'h0, cut);
      push(7, s + 73 + i, 24'h0, cut);
    end
  endtask

  task automatic drain_chk(input string nm);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_left%0d", nm, k), 64'(q[k].size()), 64'h0);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc != n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Locked and enabled out of reset; enable dropped mid second frame.
    repeat (3) @(negedge clk);
    lock   = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    push_frame(0, BIG);
    push_frame(98, BIG);
    reset = 1'b0;
    wait_cyc(117);
    enable = 1'b0;
    wait_cyc(260);
    drain_chk("en_stop");
    enable = 1'b1;
    push_frame(260, BIG);
    wait_cyc(265);
    enable = 1'b0;
    wait_cyc(378);
    drain_chk("en_restart");

    // Reset with lock low, then lock loss at request (5,2) and relock 10 cycles later.
    reset  = 1'b1;
    lock   = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    lock = 1'b1;
    @(negedge clk);
    push_frame(0, 35);
    reset = 1'b0;
    wait_cyc(35);
    lock = 1'b0;
    wait_cyc(45);
    lock = 1'b1;
    push_frame(45, BIG);
    wait_cyc(50);
    enable = 1'b0;
    wait_cyc(163);
    drain_chk("relock");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
